// File: rtl/mdom_wvb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdom_wvb_pkg
// Brief    : Shared header field map, W0 layout and state encoding for the
//            waveform-buffer readout controller.
// Revision : 1.0 - initial release
// ============================================================================
package mdom_wvb_pkg;

  // Header bundle field map
  localparam int HDR_W      = 71;
  localparam int LTC_LSB    = 0;
  localparam int LTC_W      = 48;
  localparam int START_LSB  = 48;
  localparam int STOP_LSB   = 58;
  localparam int ADDR_FLD_W = 10;
  localparam int TRIG_LSB   = 68;
  localparam int TRIG_W     = 2;
  localparam int CNST_BIT   = 70;

  localparam int HDR_WORDS  = 4;
  localparam int NSAMP_W    = 11;
  localparam int CKSUM_W    = 16;

  // W0 = {trig_src, cnst_run, 2'b00, nsamp[10:0]}
  localparam int W0_NSAMP_LSB = 0;
  localparam int W0_PAD_W     = 2;
  localparam int W0_CNST_BIT  = 13;
  localparam int W0_TRIG_LSB  = 14;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_SAMP  = 3'd2,
    ST_CKSUM = 3'd3,
    ST_DONE  = 3'd4
  } rdout_state_e;

  function automatic logic [15:0] build_w0(input logic [TRIG_W-1:0]  trig,
                                           input logic               cnst,
                                           input logic [NSAMP_W-1:0] nsamp);
    return {trig, cnst, {W0_PAD_W{1'b0}}, nsamp};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdom_wvb_rdout_skid.sv
`default_nettype none
// ============================================================================
// Module   : mdom_wvb_rdout_skid
// Brief    : 2-entry valid/ready skid buffer carrying a data word and a last
//            flag; the writer owns flow control via the exported fill level.
// Revision : 1.0 - initial release
// ============================================================================
module mdom_wvb_rdout_skid #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic [1:0]        level,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready
);

  logic [DATA_W-1:0] mem_data [2];
  logic [1:0]        mem_last;
  logic              wr_ptr;
  logic              rd_ptr;
  logic              pop;

  assign pop = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_data[0] <= '0;
      mem_data[1] <= '0;
      mem_last    <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      level       <= 2'd0;
    end else begin
      if (in_valid) begin
        mem_data[wr_ptr] <= in_data;
        mem_last[wr_ptr] <= in_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      level <= level + {1'b0, in_valid} - {1'b0, pop};
    end
  end

  // Head entry is driven straight from storage, so it holds while stalled
  assign out_valid = (level != 2'd0);
  assign out_data  = mem_data[rd_ptr];
  assign out_last  = mem_last[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/mdom_wvb_rdout_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mdom_wvb_rdout_ctrl
// Brief    : Pops event headers, emits 4 header words then the addressed
//            waveform samples through a skid buffer. Define
//            WVB_RDOUT_CHKSUM_EN to append a 16-bit checksum word.
// Revision : 1.0 - initial release
// ============================================================================
module mdom_wvb_rdout_ctrl
  import mdom_wvb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HDR_W-1:0]  hdr_bundle,
  input  logic              hdr_empty,
  output logic              hdr_rdreq,
  output logic [ADDR_W-1:0] wvb_rd_addr,
  input  logic [DATA_W-1:0] wvb_rd_data,
  output logic [DATA_W-1:0] dout_data,
  output logic              dout_valid,
  output logic              dout_last,
  input  logic              dout_ready,
  output logic              busy
);

  rdout_state_e state;
  rdout_state_e state_nxt;

  logic [LTC_W-1:0]   ltc;
  logic [TRIG_W-1:0]  trig;
  logic               cnst;
  logic [NSAMP_W-1:0] nsamp;
  logic [NSAMP_W-1:0] samp_left;
  logic [1:0]         hdr_idx;
  logic [ADDR_W-1:0]  rd_addr;

  // One-cycle issue stage: every word lands in the skid one cycle after issue
  logic               pend;
  logic               pend_ram;
  logic               pend_last;
  logic [DATA_W-1:0]  pend_word;

  logic [ADDR_W-1:0]  in_start;
  logic [ADDR_W-1:0]  in_stop;
  logic [NSAMP_W-1:0] nsamp_in;
  logic [DATA_W-1:0]  hdr_word;
  logic [DATA_W-1:0]  push_data;
  logic [1:0]         level;
  logic [2:0]         committed;
  logic               pop;
  logic               can_issue;
  logic               issue;
  logic               last_samp;
  logic               drained;

  assign in_start  = ADDR_W'(hdr_bundle[START_LSB +: ADDR_FLD_W]);
  assign in_stop   = ADDR_W'(hdr_bundle[STOP_LSB +: ADDR_FLD_W]);
  assign nsamp_in  = NSAMP_W'(ADDR_W'(in_stop - in_start)) + NSAMP_W'(1);

  assign pop       = dout_valid & dout_ready;
  // Entries the skid will hold after this edge, before counting a new issue
  assign committed = {1'b0, level} + {2'b00, pend} - {2'b00, pop};
  assign can_issue = (committed <= 3'd1);
  assign last_samp = (samp_left == NSAMP_W'(1));
  assign drained   = (level == 2'd0) && !pend;
  assign push_data = pend_ram ? wvb_rd_data : pend_word;
  assign wvb_rd_addr = rd_addr;

  always_comb begin
    case (hdr_idx)
      2'd0:    hdr_word = DATA_W'(build_w0(trig, cnst, nsamp));
      2'd1:    hdr_word = DATA_W'(ltc[47:32]);
      2'd2:    hdr_word = DATA_W'(ltc[31:16]);
      default: hdr_word = DATA_W'(ltc[15:0]);
    endcase
  end

`ifdef WVB_RDOUT_CHKSUM_EN
  logic [CKSUM_W-1:0] sum;
  logic [CKSUM_W-1:0] sum_nxt;

  // Includes the word landing this cycle so the checksum can issue back-to-back
  assign sum_nxt = pend ? (sum + CKSUM_W'(push_data)) : sum;

  always_ff @(posedge clk) begin
    if (rst || hdr_rdreq) begin
      sum <= '0;
    end else begin
      sum <= sum_nxt;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (!hdr_empty) state_nxt = ST_HDR;
      end
      ST_HDR: begin
        if (issue && (hdr_idx == 2'(HDR_WORDS - 1))) state_nxt = ST_SAMP;
      end
      ST_SAMP: begin
        if (issue && last_samp) begin
`ifdef WVB_RDOUT_CHKSUM_EN
          state_nxt = ST_CKSUM;
`else
          state_nxt = ST_DONE;
`endif
        end
      end
`ifdef WVB_RDOUT_CHKSUM_EN
      ST_CKSUM: begin
        if (issue) state_nxt = ST_DONE;
      end
`endif
      ST_DONE: begin
        if (drained) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    hdr_rdreq = 1'b0;
    issue     = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy      = 1'b0;
        hdr_rdreq = !hdr_empty && !rst;
      end
      ST_HDR:   issue = can_issue;
      ST_SAMP:  issue = can_issue;
`ifdef WVB_RDOUT_CHKSUM_EN
      ST_CKSUM: issue = can_issue;
`endif
      ST_DONE:  busy = !drained;
      default:  busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ltc       <= '0;
      trig      <= '0;
      cnst      <= 1'b0;
      nsamp     <= '0;
      samp_left <= '0;
      hdr_idx   <= 2'd0;
      rd_addr   <= '0;
      pend      <= 1'b0;
      pend_ram  <= 1'b0;
      pend_last <= 1'b0;
      pend_word <= '0;
    end else begin
      pend      <= issue;
      pend_ram  <= issue && (state == ST_SAMP);
      pend_last <= 1'b0;
      if (hdr_rdreq) begin
        ltc       <= hdr_bundle[LTC_LSB +: LTC_W];
        trig      <= hdr_bundle[TRIG_LSB +: TRIG_W];
        cnst      <= hdr_bundle[CNST_BIT];
        nsamp     <= nsamp_in;
        samp_left <= nsamp_in;
        hdr_idx   <= 2'd0;
        rd_addr   <= in_start;
      end
      if (issue) begin
        case (state)
          ST_HDR: begin
            pend_word <= hdr_word;
            hdr_idx   <= hdr_idx + 2'd1;
          end
          ST_SAMP: begin
            rd_addr   <= rd_addr + ADDR_W'(1);
            samp_left <= samp_left - NSAMP_W'(1);
`ifndef WVB_RDOUT_CHKSUM_EN
            pend_last <= last_samp;
`endif
          end
`ifdef WVB_RDOUT_CHKSUM_EN
          ST_CKSUM: begin
            pend_word <= DATA_W'(sum_nxt);
            pend_last <= 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  mdom_wvb_rdout_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (pend),
    .in_data   (push_data),
    .in_last   (pend_last),
    .level     (level),
    .out_valid (dout_valid),
    .out_data  (dout_data),
    .out_last  (dout_last),
    .out_ready (dout_ready)
  );

endmodule
`default_nettype wire

// File: tb/tb_mdom_wvb_rdout_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdom_wvb_rdout_ctrl
// Brief    : Scoreboard bench for mdom_wvb_rdout_ctrl with a header FIFO model,
//            waveform RAM model and event-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdom_wvb_rdout_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [70:0] hdr_bundle;
  logic        hdr_empty;
  logic        hdr_rdreq;
  logic [9:0]  wvb_rd_addr;
  logic [15:0] wvb_rd_data = '0;
  logic [15:0] dout_data;
  logic        dout_valid;
  logic        dout_last;
  logic        dout_ready;
  logic        busy;

  mdom_wvb_rdout_ctrl #(.DATA_W(16), .ADDR_W(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .hdr_bundle  (hdr_bundle),
    .hdr_empty   (hdr_empty),
    .hdr_rdreq   (hdr_rdreq),
    .wvb_rd_addr (wvb_rd_addr),
    .wvb_rd_data (wvb_rd_data),
    .dout_data   (dout_data),
    .dout_valid  (dout_valid),
    .dout_last   (dout_last),
    .dout_ready  (dout_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        last;
    logic        first;
    int          nw;
  } exp_t;

  exp_t        exp_q[$];
  logic [70:0] hdr_fifo[$];
  logic [15:0] ram [0:1023];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          rdreq_cnt = 0;
  int          ready_mode = 0;
  logic        in_reset = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [70:0] mk_hdr(input logic [9:0] start, input logic [9:0] stop,
                                         input logic [47:0] ltc, input logic [1:0] trig,
                                         input logic cr);
    return {cr, trig, stop, start, ltc};
  endfunction

  function automatic logic [70:0] rand_hdr(input int maxlen);
    logic [9:0]  s;
    logic [9:0]  e;
    logic [47:0] l;
    s = 10'($urandom_range(0, 1023));
    e = s + 10'($urandom_range(0, maxlen - 1));
    l = {16'($urandom), 32'($urandom)};
    return mk_hdr(s, e, l, 2'($urandom), 1'($urandom));
  endfunction

  // Reference model: expected word stream of one event from the header and RAM
  task automatic model_event(input logic [70:0] h);
    int          start;
    int          stop;
    int          n;
    int          sum;
    logic [15:0] w[$];
    exp_t        e;
    start = int'(h[57:48]);
    stop  = int'(h[67:58]);
    n     = ((stop - start + 1024) % 1024) + 1;
    w.push_back({h[69:68], h[70], 2'b00, 11'(n)});
    w.push_back(h[47:32]);
    w.push_back(h[31:16]);
    w.push_back(h[15:0]);
    for (int i = 0; i < n; i++) w.push_back(ram[(start + i) % 1024]);
`ifdef WVB_RDOUT_CHKSUM_EN
    sum = 0;
    foreach (w[i]) sum += int'(w[i]);
    w.push_back(16'(sum));
`else
    sum = 0;
`endif
    foreach (w[i]) begin
      e.data  = w[i];
      e.last  = (i == w.size() - 1);
      e.first = (i == 0);
      e.nw    = w.size();
      exp_q.push_back(e);
    end
  endtask

  task automatic push_event(input logic [70:0] h);
    model_event(h);
    hdr_fifo.push_back(h);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || hdr_fifo.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      tests++;
      fails++;
      $display("FAIL timeout: %0d words outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Waveform RAM: data valid one cycle after the address
  initial forever begin
    @(posedge clk);
    wvb_rd_data <= ram[wvb_rd_addr];
  end

  // First-word-fall-through header FIFO
  initial begin
    logic pop;
    hdr_empty  = 1'b1;
    hdr_bundle = '0;
    forever begin
      @(negedge clk);
      pop = hdr_rdreq;
      if (pop) begin
        rdreq_cnt++;
        check("rdreq_while_empty", {31'b0, hdr_empty}, 32'd0);
      end
      @(posedge clk);
      #1;
      if (pop && hdr_fifo.size() > 0) void'(hdr_fifo.pop_front());
      hdr_empty  = (hdr_fifo.size() == 0);
      hdr_bundle = hdr_empty ? '0 : hdr_fifo[0];
    end
  end

  initial begin
    dout_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      dout_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
    end
  end

  // Monitor: pops the scoreboard on each transfer and checks stall stability
  initial begin
    logic        pv;
    logic        pr;
    logic [15:0] pd;
    logic        pl;
    int          t0;
    exp_t        e;
    pv = 1'b0; pr = 1'b0; pd = '0; pl = 1'b0; t0 = 0;
    forever begin
      @(negedge clk);
      if (in_reset || rst) begin
        pv = 1'b0;
        continue;
      end
      if (pv && !pr) begin
        check("stall_valid", {31'b0, dout_valid}, 32'd1);
        check("stall_data", {16'b0, dout_data}, {16'b0, pd});
        check("stall_last", {31'b0, dout_last}, {31'b0, pl});
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_word: got 0x%0h, required no word", dout_data);
        end else begin
          e = exp_q.pop_front();
          check("word_data", {16'b0, dout_data}, {16'b0, e.data});
          check("word_last", {31'b0, dout_last}, {31'b0, e.last});
          if (e.first) t0 = cyc;
          if (e.last && ready_mode == 0) check("throughput", cyc - t0, e.nw - 1);
        end
      end
      pv = dout_valid; pr = dout_ready; pd = dout_data; pl = dout_last;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [70:0] h3[3];
    logic [70:0] ha;
    logic [70:0] hb;
    int          n;
    foreach (ram[i]) ram[i] = 16'($urandom);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hdr_rdreq", {31'b0, hdr_rdreq}, 32'd0);
    check("rst_rd_addr", {22'b0, wvb_rd_addr}, 32'd0);
    check("rst_dout_data", {16'b0, dout_data}, 32'd0);
    check("rst_dout_valid", {31'b0, dout_valid}, 32'd0);
    check("rst_dout_last", {31'b0, dout_last}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed: basic event, wrap, single sample, full buffer
    push_event(mk_hdr(10'h010, 10'h013, 48'h123456789ABC, 2'd2, 1'b0));
    wait_done(5000);
    push_event(mk_hdr(10'h3FE, 10'h001, 48'h0000DEADBEEF, 2'd1, 1'b1));
    wait_done(5000);
    push_event(mk_hdr(10'h200, 10'h200, 48'hFFFF00000001, 2'd3, 1'b0));
    wait_done(5000);
    push_event(mk_hdr(10'h201, 10'h200, 48'h0A0B0C0D0E0F, 2'd0, 1'b1));
    wait_done(5000);

    // Random back-to-back events with ready held high
    for (int i = 0; i < 4; i++) push_event(rand_hdr(40));
    wait_done(5000);

    // Three queued events, ready high then 30% duty
    foreach (h3[i]) h3[i] = rand_hdr(30);
    rdreq_cnt = 0;
    foreach (h3[i]) push_event(h3[i]);
    wait_done(5000);
    check("rdreq_count_ready_high", rdreq_cnt, 3);
    ready_mode = 1;
    rdreq_cnt = 0;
    foreach (h3[i]) push_event(h3[i]);
    wait_done(5000);
    check("rdreq_count_ready_rand", rdreq_cnt, 3);
    ready_mode = 0;
    repeat (2) @(negedge clk);

    // Reset mid-event; the following header must still be read cleanly
    rdreq_cnt = 0;
    ha = mk_hdr(10'h100, 10'h113, 48'h111122223333, 2'd1, 1'b0);
    hb = rand_hdr(16);
    push_event(ha);
    hdr_fifo.push_back(hb);
    n = 0;
    while (exp_q.size() > 20 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL reset_setup_timeout: %0d words outstanding, required 20", exp_q.size());
    end
    @(posedge clk);
    #2;
    in_reset = 1'b1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #2;
    check("abort_dout_valid", {31'b0, dout_valid}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    model_event(hb);
    in_reset = 1'b0;
    wait_done(5000);
    check("rdreq_count_reset", rdreq_cnt, 2);

`ifdef WVB_RDOUT_CHKSUM_EN
    ram[10'h100] = 16'hFFFF;
    ram[10'h101] = 16'h0002;
    push_event(mk_hdr(10'h100, 10'h101, 48'h000000000001, 2'd2, 1'b0));
    wait_done(5000);
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdom_wvb_rdout_ctrl.md
MDOM_WVB_RDOUT_CTRL -- requirements
Module: mdom_wvb_rdout_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, waveform sample and output word width.
REQ-002 Parameter ADDR_W, default 10, waveform buffer address width.
REQ-003 clk  in  1  sole clock; all logic rising-edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 hdr_bundle  in  71  header from FWFT header FIFO: [47:0] evt_ltc, [57:48] start_addr, [67:58] stop_addr, [69:68] trig_src, [70] cnst_run.
REQ-006 hdr_empty  in  1  header FIFO empty.
REQ-007 hdr_rdreq  out  1  header FIFO pop, one-cycle pulse.
REQ-008 wvb_rd_addr  out  ADDR_W  waveform buffer read address.
REQ-009 wvb_rd_data  in  DATA_W  waveform buffer data, valid one cycle after wvb_rd_addr.
REQ-010 dout_data  out  DATA_W  output word.
REQ-011 dout_valid  out  1  output word valid.
REQ-012 dout_last  out  1  final word of event, qualified by dout_valid.
REQ-013 dout_ready  in  1  downstream accept; transfer when dout_valid & dout_ready.
REQ-014 busy  out  1  high from header latch until last word transferred.

Function
REQ-015 States: IDLE, HDR, SAMP, CKSUM, DONE.
REQ-016 IDLE, hdr_empty low: latch hdr_bundle, pulse hdr_rdreq one cycle, go HDR.
REQ-017 nsamp = ((stop_addr - start_addr) mod 2^ADDR_W) + 1, 11 bits, range 1..1024; start==stop gives 1.
REQ-018 HDR emits 4 words in order: W0 = {trig_src, cnst_run, 2'b00, nsamp[10:0]}; W1 = evt_ltc[47:32]; W2 = evt_ltc[31:16]; W3 = evt_ltc[15:0].
REQ-019 SAMP reads addresses start_addr, start_addr+1, ... stop_addr, wrapping 1023->0; emits exactly nsamp sample words in address order.
REQ-020 Output never drops or duplicates words under arbitrary dout_ready; read address advances only when the output buffer can absorb the in-flight read.
REQ-021 Output goes through a 2-entry skid buffer; dout_data/dout_last stable while dout_valid & !dout_ready.
REQ-022 Without checksum, dout_last marks the final sample word.
REQ-023 DONE: wait until skid buffer drains, deassert busy, return IDLE; the next header is not popped before then.
REQ-024 Back-to-back headers: minimum 1 idle cycle between last transfer and next hdr_rdreq.
REQ-025 hdr_rdreq never asserted while hdr_empty is high.
REQ-026 Sustained throughput with dout_ready held high: one word per cycle after first header word.

Reset
REQ-027 rst mid-event aborts immediately: state IDLE, skid buffer emptied, partial event discarded, no header popped in that cycle.
REQ-028 Reset values: hdr_rdreq 0, wvb_rd_addr 0, dout_data 0, dout_valid 0, dout_last 0, busy 0.

Configuration
REQ-029 Macro WVB_RDOUT_CHKSUM_EN defined: after the final sample, CKSUM emits one word = sum mod 2^16 of all preceding words of the event (W0..W3 and samples); dout_last moves to that word.
REQ-030 Macro undefined: CKSUM state and adder absent; SAMP proceeds directly to DONE.

Structure
REQ-031 Shared package mdom_wvb_pkg holds header field offsets/widths, header word count (4), state enum, W0 layout constants.
REQ-032 Sub-module mdom_wvb_rdout_skid implements the 2-entry valid/ready skid buffer (data + last).

Verification
REQ-033 start=0x010, stop=0x013, ltc=0x123456789ABC, trig_src=2, cnst_run=0, ready high -> words 0x8004, 0x1234, 0x5678, 0x9ABC, then samples at addrs 0x010..0x013, last on 4th sample.
REQ-034 start=0x3FE, stop=0x001 -> nsamp 4, W0[10:0]=4, addresses 0x3FE, 0x3FF, 0x000, 0x001.
REQ-035 start=stop=0x200 -> nsamp 1; start=0x201, stop=0x200 -> nsamp 1024, W0[10:0]=0x400.
REQ-036 dout_ready random 30% duty over 3 queued events -> output stream bit-identical to ready-high run, hdr_rdreq pulses exactly 3.
REQ-037 rst asserted 2 cycles into SAMP -> next cycle dout_valid 0, busy 0; next header read cleanly from FIFO.
REQ-038 With WVB_RDOUT_CHKSUM_EN, samples 0xFFFF,0x0002 after header 0x8002,0,0,1 -> checksum word 0x8004 with dout_last.
